// File: rtl/pbch_re_extractor_if.sv
// Signal bundle around the PBCH RE extractor: cell-ID/symbol control, FFT bin input and LLR output.
// PBCH_DMRS_OUT_EN adds the raw DMRS pulse stream for the channel estimator.
interface pbch_re_extractor_if #(
  parameter int IN_DW  = 32,
  parameter int LLR_DW = 8
);
  logic [9:0]          N_id_i;
  logic                N_id_valid_i;
  logic                PBCH_start_i;
  logic [IN_DW-1:0]    s_axis_in_tdata;
  logic                s_axis_in_tvalid;
  logic [2*LLR_DW-1:0] m_axis_out_tdata;
  logic                m_axis_out_tvalid;
  logic                m_axis_out_tready;
  logic                m_axis_out_tlast;
  logic                overflow_o;
`ifdef PBCH_DMRS_OUT_EN
  logic [IN_DW-1:0]    m_axis_dmrs_tdata;
  logic                m_axis_dmrs_tvalid;
  logic                m_axis_dmrs_tlast;

  modport master (
    output N_id_i, N_id_valid_i, PBCH_start_i, s_axis_in_tdata, s_axis_in_tvalid, m_axis_out_tready,
    input  m_axis_out_tdata, m_axis_out_tvalid, m_axis_out_tlast, overflow_o,
    input  m_axis_dmrs_tdata, m_axis_dmrs_tvalid, m_axis_dmrs_tlast
  );
  modport slave (
    input  N_id_i, N_id_valid_i, PBCH_start_i, s_axis_in_tdata, s_axis_in_tvalid, m_axis_out_tready,
    output m_axis_out_tdata, m_axis_out_tvalid, m_axis_out_tlast, overflow_o,
    output m_axis_dmrs_tdata, m_axis_dmrs_tvalid, m_axis_dmrs_tlast
  );
`else
  modport master (
    output N_id_i, N_id_valid_i, PBCH_start_i, s_axis_in_tdata, s_axis_in_tvalid, m_axis_out_tready,
    input  m_axis_out_tdata, m_axis_out_tvalid, m_axis_out_tlast, overflow_o
  );
  modport slave (
    input  N_id_i, N_id_valid_i, PBCH_start_i, s_axis_in_tdata, s_axis_in_tvalid, m_axis_out_tready,
    output m_axis_out_tdata, m_axis_out_tvalid, m_axis_out_tlast, overflow_o
  );
`endif
endinterface

// File: rtl/pbch_re_extractor.sv
// Extracts the 432 PBCH data REs per SSB from FFT bins, converts them to LLR pairs and buffers them.
// Optional PBCH_DMRS_OUT_EN exports the raw DMRS REs as an unbuffered pulse stream.
module pbch_re_extractor #(
  parameter int IN_DW    = 32,
  parameter int LLR_DW   = 8,
  parameter int FIFO_LEN = 512
) (
  input  logic               clk_i,
  input  logic               reset_i,
  pbch_re_extractor_if.slave bus,
  output logic [1:0]         state_o
);
  localparam int HW = IN_DW / 2;
  localparam int SH = HW - LLR_DW;
  localparam int AW = $clog2(FIFO_LEN);
  localparam int OW = 2 * LLR_DW + 1;
  localparam logic signed [HW-1:0] LLR_MAX = HW'((1 <<< (LLR_DW - 1)) - 1);
  localparam logic signed [HW-1:0] LLR_MIN = HW'(-(1 <<< (LLR_DW - 1)));

  // Output handshake: a word transfers on a cycle where tvalid & tready are both high; while
  // tvalid is high and tready low, tdata/tlast/tvalid hold. The input side has no backpressure.

  typedef enum logic [1:0] {WAIT_NID = 2'd0, WAIT_SSB = 2'd1, SYM = 2'd2, WAIT_SYM = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [1:0]  nid_pend_q, v_q, sym_q;
  logic [7:0]  sc_q;
  logic        take, in_fire, is_pbch, is_data, is_dmrs;
  logic [7:0]  cur_sc;
  logic [1:0]  cur_sym, cur_v;
  logic        nid_unused;

  assign nid_unused = ^bus.N_id_i[9:2];
  assign state_o    = state_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= WAIT_NID;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_NID:           if (bus.N_id_valid_i) state_d = WAIT_SSB;
      WAIT_SSB, WAIT_SYM: if (bus.PBCH_start_i) state_d = SYM;
      SYM: if (in_fire && cur_sc == 8'd239) state_d = (cur_sym == 2'd2) ? WAIT_SSB : WAIT_SYM;
      default: state_d = WAIT_NID;
    endcase
  end

  // The bin coincident with PBCH_start_i is subcarrier 0 of the symbol being (re)started,
  // so the classification position is resolved combinationally from the start pulse.
  always_comb begin
    take    = 1'b0;
    cur_sc  = sc_q;
    cur_sym = sym_q;
    cur_v   = v_q;
    unique case (state_q)
      WAIT_SSB: begin
        take    = bus.PBCH_start_i;
        cur_sc  = 8'd0;
        cur_sym = 2'd0;
        cur_v   = nid_pend_q;
      end
      WAIT_SYM: begin
        take   = bus.PBCH_start_i;
        cur_sc = 8'd0;
      end
      SYM: begin
        take = 1'b1;
        if (bus.PBCH_start_i) cur_sc = 8'd0;
      end
      default: take = 1'b0;
    endcase
    in_fire = take & bus.s_axis_in_tvalid;
    is_pbch = (cur_sym != 2'd1) || (cur_sc < 8'd48) || (cur_sc >= 8'd192);
    is_dmrs = in_fire & is_pbch & (cur_sc[1:0] == cur_v);
    is_data = in_fire & is_pbch & (cur_sc[1:0] != cur_v);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      nid_pend_q <= 2'd0;
      v_q        <= 2'd0;
      sym_q      <= 2'd0;
      sc_q       <= 8'd0;
    end else begin
      if (bus.N_id_valid_i) nid_pend_q <= bus.N_id_i[1:0];
      if (state_q == WAIT_SSB && bus.PBCH_start_i) begin
        v_q   <= nid_pend_q;
        sym_q <= 2'd0;
      end
      if (in_fire) sc_q <= (cur_sc == 8'd239) ? 8'd0 : cur_sc + 8'd1;
      else if (take && bus.PBCH_start_i) sc_q <= 8'd0;
      if (in_fire && cur_sc == 8'd239 && cur_sym != 2'd2) sym_q <= cur_sym + 2'd1;
    end
  end

  // Stage 1: classification result and the raw bin.
  logic             s1_data_q, s1_dmrs_q;
  logic [IN_DW-1:0] s1_bin_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_data_q <= 1'b0;
      s1_dmrs_q <= 1'b0;
      s1_bin_q  <= '0;
    end else begin
      s1_data_q <= is_data;
      s1_dmrs_q <= is_dmrs;
      if (in_fire) s1_bin_q <= bus.s_axis_in_tdata;
    end
  end

  function automatic logic [LLR_DW-1:0] to_llr(input logic signed [HW-1:0] x);
    logic signed [HW-1:0] s;
    s = x >>> SH;
    if (s > LLR_MAX) s = LLR_MAX;
    if (s < LLR_MIN) s = LLR_MIN;
    return s[LLR_DW-1:0];
  endfunction

  // Stage 2: scaled word plus tlast tag; data_cnt advances even when the FIFO drops the word.
  logic            s2_valid_q;
  logic [OW-1:0]   s2_word_q;
  logic [8:0]      data_cnt_q;
  logic [LLR_DW-1:0] llr_re, llr_im;

  assign llr_re = to_llr($signed(s1_bin_q[HW-1:0]));
  assign llr_im = to_llr($signed(s1_bin_q[IN_DW-1:HW]));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s2_valid_q <= 1'b0;
      s2_word_q  <= '0;
      data_cnt_q <= 9'd0;
    end else begin
      s2_valid_q <= s1_data_q;
      if (s1_data_q) begin
        s2_word_q  <= {data_cnt_q == 9'd431, llr_im, llr_re};
        data_cnt_q <= (data_cnt_q == 9'd431) ? 9'd0 : data_cnt_q + 9'd1;
      end
    end
  end

  // First-word-fall-through FIFO; a same-cycle read frees the slot for a write when full.
  logic [OW-1:0] mem [FIFO_LEN];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          empty, full, rd_en, wr_en, overflow_q;
  logic [OW-1:0] rd_word;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign rd_en   = !empty && bus.m_axis_out_tready;
  assign wr_en   = s2_valid_q && (!full || rd_en);
  assign rd_word = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= s2_word_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (rd_en) rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      if (s2_valid_q && !wr_en) overflow_q <= 1'b1;
    end
  end

  assign bus.m_axis_out_tvalid = !empty;
  assign bus.m_axis_out_tdata  = empty ? '0 : rd_word[2*LLR_DW-1:0];
  assign bus.m_axis_out_tlast  = !empty && rd_word[OW-1];
  assign bus.overflow_o        = overflow_q;

`ifdef PBCH_DMRS_OUT_EN
  logic [7:0]       dmrs_cnt_q;
  logic             dmrs_valid_q, dmrs_last_q;
  logic [IN_DW-1:0] dmrs_data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dmrs_cnt_q   <= 8'd0;
      dmrs_valid_q <= 1'b0;
      dmrs_last_q  <= 1'b0;
      dmrs_data_q  <= '0;
    end else begin
      dmrs_valid_q <= s1_dmrs_q;
      dmrs_last_q  <= s1_dmrs_q && (dmrs_cnt_q == 8'd143);
      dmrs_data_q  <= s1_dmrs_q ? s1_bin_q : '0;
      if (s1_dmrs_q) dmrs_cnt_q <= (dmrs_cnt_q == 8'd143) ? 8'd0 : dmrs_cnt_q + 8'd1;
    end
  end

  assign bus.m_axis_dmrs_tdata  = dmrs_data_q;
  assign bus.m_axis_dmrs_tvalid = dmrs_valid_q;
  assign bus.m_axis_dmrs_tlast  = dmrs_last_q;
`else
  logic dmrs_unused;
  assign dmrs_unused = s1_dmrs_q;
`endif
endmodule

// File: tb/tb_pbch_re_extractor.sv
// Directed bench for pbch_re_extractor: scaling vector table plus SSB-level sequences.
// Define PBCH_DMRS_OUT_EN to also check the DMRS pulse stream.
module tb_pbch_re_extractor;
  localparam int IN_DW = 32, LLR_DW = 8, FIFO_LEN = 512, OW = 2 * LLR_DW + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state;
  int         checks = 0, errors = 0;

  pbch_re_extractor_if #(.IN_DW(IN_DW), .LLR_DW(LLR_DW)) bus ();
  pbch_re_extractor #(.IN_DW(IN_DW), .LLR_DW(LLR_DW), .FIFO_LEN(FIFO_LEN)) dut (
    .clk_i(clk), .reset_i(rst), .bus(bus), .state_o(state));

  // clock / reset / ready generation
  always #5 clk = ~clk;
  bit   rand_rdy = 1'b0;
  logic rdy_level = 1'b1;
  always @(posedge clk) begin
    #1;
    bus.m_axis_out_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_level;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard state
  logic [OW-1:0] exp_q[$];
  int  model_cnt = 0, words_seen = 0, tlast_seen = 0;
  bit  no_pop = 1'b0, sink_en = 1'b1, fix_en = 1'b0;
  logic [31:0] fix_bin;
  logic [15:0] fix_exp;
`ifdef PBCH_DMRS_OUT_EN
  logic [IN_DW:0] exp_dq[$];
  int  dmrs_cnt = 0, dmrs_seen = 0, dmrs_last_seen = 0;
`endif

  function automatic logic [7:0] llr(input logic [15:0] x);
    logic signed [15:0] s;
    s = $signed(x) >>> 8;
    if (s > 16'sd127) return 8'h7f;
    if (s < -16'sd128) return 8'h80;
    return s[7:0];
  endfunction

  function automatic logic [31:0] bin_of(input int sym, input int sc);
    logic [15:0] re, im;
    re = 16'(sc * 137 - 16000);
    im = 16'(sym * 9000 + sc * 50 - 20000);
    return fix_en ? fix_bin : {im, re};
  endfunction

  function automatic void model_push(input int sym, input int sc, input int v, input logic [31:0] bin);
    bit pbch, last;
    logic [15:0] w;
    if (!sink_en) return;
    pbch = (sym != 1) || (sc < 48) || (sc >= 192);
    if (pbch && (sc % 4) != v) begin
      w    = fix_en ? fix_exp : {llr(bin[31:16]), llr(bin[15:0])};
      last = (model_cnt == 431);
      model_cnt = last ? 0 : model_cnt + 1;
      if (!no_pop || exp_q.size() < FIFO_LEN) exp_q.push_back({last, w});
    end
`ifdef PBCH_DMRS_OUT_EN
    if (pbch && (sc % 4) == v) begin
      exp_dq.push_back({dmrs_cnt == 143, bin});
      dmrs_cnt = (dmrs_cnt == 143) ? 0 : dmrs_cnt + 1;
    end
`endif
  endfunction

  // output monitor
  bit            hold_chk = 1'b0;
  logic [OW:0]   hold_word;
  logic [OW-1:0] exp_w;
  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk)
        check("hold_stable", 64'({bus.m_axis_out_tvalid, bus.m_axis_out_tlast, bus.m_axis_out_tdata}),
              64'(hold_word));
      hold_chk  = bus.m_axis_out_tvalid && !bus.m_axis_out_tready;
      hold_word = {bus.m_axis_out_tvalid, bus.m_axis_out_tlast, bus.m_axis_out_tdata};
      if (bus.m_axis_out_tvalid && bus.m_axis_out_tready) begin
        words_seen++;
        if (bus.m_axis_out_tlast) tlast_seen++;
        check("word_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check("out_word", 64'({bus.m_axis_out_tlast, bus.m_axis_out_tdata}), 64'(exp_w));
        end
      end
`ifdef PBCH_DMRS_OUT_EN
      if (bus.m_axis_dmrs_tvalid) begin
        dmrs_seen++;
        if (bus.m_axis_dmrs_tlast) dmrs_last_seen++;
        check("dmrs_expected", 64'(exp_dq.size() > 0), 64'd1);
        if (exp_dq.size() > 0)
          check("dmrs_word", 64'({bus.m_axis_dmrs_tlast, bus.m_axis_dmrs_tdata}), 64'(exp_dq.pop_front()));
      end
`endif
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_axis_in_tvalid = 1'b0;
    bus.PBCH_start_i     = 1'b0;
    bus.N_id_valid_i     = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
`ifdef PBCH_DMRS_OUT_EN
    exp_dq.delete();
    dmrs_cnt = 0;
`endif
  endtask

  task automatic nid(input logic [9:0] id);
    bus.N_id_i       = id;
    bus.N_id_valid_i = 1'b1;
    tick();
    bus.N_id_valid_i = 1'b0;
  endtask

  task automatic drive_sym(input int sym, input int v, input int n);
    logic [31:0] bin;
    for (int sc = 0; sc < n; sc++) begin
      if (sc != 0 && $urandom_range(0, 7) == 0) begin
        bus.s_axis_in_tvalid = 1'b0;
        bus.PBCH_start_i     = 1'b0;
        tick();
      end
      bin = bin_of(sym, sc);
      bus.s_axis_in_tvalid = 1'b1;
      bus.PBCH_start_i     = (sc == 0);
      bus.s_axis_in_tdata  = bin;
      model_push(sym, sc, v, bin);
      tick();
    end
    bus.s_axis_in_tvalid = 1'b0;
    bus.PBCH_start_i     = 1'b0;
    repeat ($urandom_range(1, 4)) tick();
  endtask

  task automatic drive_ssb(input int v);
    for (int s = 0; s < 3; s++) drive_sym(s, v, 240);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) tick();
    repeat (6) tick();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [31:0] bin;
    logic [15:0] exp_word;
  } vec_t;
  vec_t vecs[6];

  int w0, t0;

  initial begin
    vecs[0] = '{32'hC000_4000, 16'hC040};
    vecs[1] = '{32'h8000_7FFF, 16'h807F};
    vecs[2] = '{32'hFFFF_00FF, 16'hFF00};
    vecs[3] = '{32'h0100_FF00, 16'h01FF};
    vecs[4] = '{32'h017F_FF7F, 16'h01FF};
    vecs[5] = '{32'hCFC7_3039, 16'hCF30};

    bus.N_id_i = '0; bus.N_id_valid_i = 1'b0; bus.PBCH_start_i = 1'b0;
    bus.s_axis_in_tdata = '0; bus.s_axis_in_tvalid = 1'b0;
    do_reset();

    check("rst_tvalid", 64'(bus.m_axis_out_tvalid), 64'd0);
    check("rst_tdata", 64'(bus.m_axis_out_tdata), 64'd0);
    check("rst_tlast", 64'(bus.m_axis_out_tlast), 64'd0);
    check("rst_overflow", 64'(bus.overflow_o), 64'd0);
    check("rst_state", 64'(state), 64'd0);

    // first-word latency: sc0 is DMRS for v=0, sc1 is the first data RE
    nid(10'd0);
    check("state_wait_ssb", 64'(state), 64'd1);
    bus.PBCH_start_i = 1'b1; bus.s_axis_in_tvalid = 1'b1; bus.s_axis_in_tdata = bin_of(0, 0);
    model_push(0, 0, 0, bin_of(0, 0));
    tick();
    check("state_sym", 64'(state), 64'd2);
    bus.PBCH_start_i = 1'b0; bus.s_axis_in_tdata = bin_of(0, 1);
    model_push(0, 1, 0, bin_of(0, 1));
    tick();
    bus.s_axis_in_tvalid = 1'b0;
    @(negedge clk); check("lat_cycle1", 64'(bus.m_axis_out_tvalid), 64'd0);
    @(negedge clk); check("lat_cycle2", 64'(bus.m_axis_out_tvalid), 64'd0);
    @(negedge clk); check("lat_cycle3", 64'(bus.m_axis_out_tvalid), 64'd1);
    wait_drain("lat_drain");
    do_reset();

    // full SSB with v=0
    nid(10'd0);
    w0 = words_seen; t0 = tlast_seen;
    drive_ssb(0);
    wait_drain("ssb_v0_drain");
    check("ssb_v0_words", 64'(words_seen - w0), 64'd432);
    check("ssb_v0_tlast", 64'(tlast_seen - t0), 64'd1);
    check("ssb_v0_state", 64'(state), 64'd1);

    // scaling table, N_id=1003 -> v=3
    nid(10'd1003);
    fix_en = 1'b1;
    foreach (vecs[i]) begin
      fix_bin = vecs[i].bin;
      fix_exp = vecs[i].exp_word;
      drive_ssb(3);
      wait_drain($sformatf("vec%0d_drain", i));
    end
    fix_en = 1'b0;

    // backpressure: one SSB fits, two do not
    nid(10'd0);
    rdy_level = 1'b0; no_pop = 1'b1;
    drive_ssb(0);
    repeat (10) tick();
    check("bp1_tvalid", 64'(bus.m_axis_out_tvalid), 64'd1);
    check("bp1_overflow", 64'(bus.overflow_o), 64'd0);
    no_pop = 1'b0; rdy_level = 1'b1;
    wait_drain("bp1_drain");
    check("bp1_overflow_after", 64'(bus.overflow_o), 64'd0);
    rdy_level = 1'b0; no_pop = 1'b1;
    w0 = words_seen; t0 = tlast_seen;
    drive_ssb(0);
    drive_ssb(0);
    repeat (10) tick();
    check("bp2_overflow", 64'(bus.overflow_o), 64'd1);
    no_pop = 1'b0; rdy_level = 1'b1;
    wait_drain("bp2_drain");
    check("bp2_words", 64'(words_seen - w0), 64'(FIFO_LEN));
    rand_rdy = 1'b1;
    drive_ssb(0);
    wait_drain("bp3_drain");
    rand_rdy = 1'b0;
    check("bp3_tlast", 64'(tlast_seen - t0), 64'd2);
    check("bp3_overflow_sticky", 64'(bus.overflow_o), 64'd1);

    // restart of symbol 0 after 100 subcarriers
    do_reset();
    check("rst2_overflow", 64'(bus.overflow_o), 64'd0);
    nid(10'd0);
    w0 = words_seen; t0 = tlast_seen;
    drive_sym(0, 0, 100);
    drive_ssb(0);
    wait_drain("restart_drain");
    check("restart_words", 64'(words_seen - w0), 64'd507);
    check("restart_tlast", 64'(tlast_seen - t0), 64'd1);

    // N_id change mid-SSB takes effect on the next SSB
    do_reset();
    nid(10'd5);
    drive_sym(0, 1, 240);
    nid(10'd6);
    drive_sym(1, 1, 240);
    drive_sym(2, 1, 240);
    drive_ssb(2);
    wait_drain("nid_change_drain");

    // reset mid-symbol flushes output and requires a fresh N_id
    rdy_level = 1'b0;
    drive_sym(0, 2, 60);
    repeat (4) tick();
    check("pre_rst_tvalid", 64'(bus.m_axis_out_tvalid), 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_tvalid", 64'(bus.m_axis_out_tvalid), 64'd0);
    check("mid_rst_state", 64'(state), 64'd0);
    rst = 1'b0;
    exp_q.delete(); model_cnt = 0;
`ifdef PBCH_DMRS_OUT_EN
    exp_dq.delete(); dmrs_cnt = 0;
`endif
    rdy_level = 1'b1;
    w0 = words_seen;
    sink_en = 1'b0;
    drive_sym(0, 0, 240);
    repeat (10) tick();
    sink_en = 1'b1;
    check("no_nid_words", 64'(words_seen - w0), 64'd0);
    check("no_nid_state", 64'(state), 64'd0);
    nid(10'd7);
    drive_ssb(3);
    wait_drain("post_rst_drain");
    check("post_rst_words", 64'(words_seen - w0), 64'd432);

`ifdef PBCH_DMRS_OUT_EN
    do_reset();
    nid(10'd2);
    w0 = dmrs_seen; t0 = dmrs_last_seen;
    drive_ssb(2);
    wait_drain("dmrs_ssb_drain");
    check("dmrs_count", 64'(dmrs_seen - w0), 64'd144);
    check("dmrs_tlast", 64'(dmrs_last_seen - t0), 64'd1);
    check("dmrs_queue_empty", 64'(exp_dq.size()), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
